intrapred_sequencer: RTL and testbench
======================================

INTRAPRED_SEQUENCER -- requirements
Module: intrapred_sequencer

Interface
REQ-001 SHALL have parameter MB_NUMBER_BITS, default 12: mbnumber width is MB_NUMBER_BITS+1.
REQ-002 SHALL have parameter PIPE_LAT, default 5: enable cycles per macroblock (extract, mode, residual, SAD, save); legal range 1..16.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to process a frame.
REQ-006 SHALL have port num_mbs, input, MB_NUMBER_BITS+1: macroblocks in the frame; sampled only when start is accepted.
REQ-007 SHALL have port stall, input, 1: downstream backpressure; freezes sequencing while high.
REQ-008 SHALL have port abort, input, 1: cancels the frame in progress.
REQ-009 SHALL have port enable, output, 1: datapath enable, fanned out to all extractor/moder/reser/sader/saver instances.
REQ-010 SHALL have port mbnumber, output, MB_NUMBER_BITS+1: current macroblock index.
REQ-011 SHALL have port mb_done, output, 1: one-cycle pulse when a macroblock completes its PIPE_LAT cycles.
REQ-012 SHALL have port busy, output, 1: high in RUN and DONE states.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE, with a registered state.
REQ-015 IDLE: start=1 and num_mbs!=0 SHALL take the FSM to RUN, latch num_mbs, and clear mbnumber and lat_cnt.
REQ-016 IDLE: start=1 and num_mbs==0 SHALL take the FSM to DONE without ever asserting enable.
REQ-017 RUN: enable SHALL equal !stall, combinationally from the registered state.
REQ-018 RUN with stall=1: lat_cnt, mbnumber and state SHALL hold, and mb_done SHALL stay 0.
REQ-019 RUN with stall=0: lat_cnt SHALL increment each cycle; at lat_cnt==PIPE_LAT-1, mb_done SHALL pulse in that cycle and lat_cnt SHALL return to 0.
REQ-020 At that point, if mbnumber==latched num_mbs-1, the FSM SHALL go to DONE and mbnumber SHALL hold; otherwise mbnumber SHALL increment by 1.
REQ-021 Frame latency SHALL be num_mbs*PIPE_LAT + stall cycles from start acceptance to the done pulse, with done asserted the cycle after the final mb_done.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; mbnumber SHALL return to 0 on entering IDLE.
REQ-023 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 abort=1 in RUN or DONE SHALL go to IDLE next cycle with no done pulse; abort takes priority over stall and completion.
REQ-025 If abort and the final mb_done coincide, mb_done SHALL still pulse, done SHALL NOT.
REQ-026 Counters SHALL NOT wrap: mbnumber never exceeds latched num_mbs-1; lat_cnt is $clog2(PIPE_LAT+1) bits.
REQ-027 A num_mbs change during RUN SHALL have no effect.

Reset
REQ-028 reset low SHALL immediately force state=IDLE, lat_cnt=0, mbnumber=0, latched count=0, enable=0, mb_done=0, busy=0, done=0, including mid-frame.
REQ-029 After reset deasserts, the first start SHALL be accepted in the first clk edge.

Structure
REQ-030 The state enum (IDLE/RUN/DONE) and the default PIPE_LAT constant SHALL live in shared package intrapred_pkg.
REQ-031 No sub-module SHALL be used: FSM and counters in one always_ff plus one always_comb.
REQ-032 intrapred SHALL instantiate intrapred_sequencer and drive its enable/mbnumber from it.

Verification
REQ-033 start, num_mbs=3, stall=0 -> enable high 15 cycles; mbnumber 0,1,2 five cycles each; mb_done at cycles 5,10,15; done at cycle 16.
REQ-034 num_mbs=2, stall high 3 cycles during MB0 lat_cnt=2 -> enable low those cycles, mbnumber holds 0, done at cycle 14.
REQ-035 start with num_mbs=0 -> done next cycle, enable never high, busy high for 1 cycle.
REQ-036 num_mbs=4, abort at MB1 lat_cnt=3 -> IDLE next cycle, mbnumber=0, no done; new start then runs normally.
REQ-037 reset pulled low mid-frame (MB2) -> all outputs 0 asynchronously; start during RUN -> ignored, frame count unchanged.
REQ-038 num_mbs=8191 (max, MB_NUMBER_BITS=12) -> last mbnumber=8190, no wrap, single done pulse.

Source files
------------

// File: rtl/intrapred_pkg.sv
// rtl/intrapred_pkg.sv - shared sequencer state encoding and default pipeline latency
package intrapred_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int PIPE_LAT_DEFAULT = 5;

endpackage

// File: rtl/intrapred.sv
// rtl/intrapred.sv - intra prediction wrapper; the sequencer drives the shared datapath enable
module intrapred
  import intrapred_pkg::*;
#(
  parameter int MB_NUMBER_BITS = 12,
  parameter int PIPE_LAT       = PIPE_LAT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MB_NUMBER_BITS:0] num_mbs,
  input  logic                    stall,
  input  logic                    abort,
  output logic                    enable,
  output logic [MB_NUMBER_BITS:0] mbnumber,
  output logic                    mb_done,
  output logic                    busy,
  output logic                    done
);

  intrapred_sequencer #(
    .MB_NUMBER_BITS (MB_NUMBER_BITS),
    .PIPE_LAT       (PIPE_LAT)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_mbs  (num_mbs),
    .stall    (stall),
    .abort    (abort),
    .enable   (enable),
    .mbnumber (mbnumber),
    .mb_done  (mb_done),
    .busy     (busy),
    .done     (done)
  );

endmodule

// File: rtl/intrapred_sequencer.sv
// rtl/intrapred_sequencer.sv - frame sequencer: walks macroblocks, PIPE_LAT enable cycles each
module intrapred_sequencer
  import intrapred_pkg::*;
#(
  parameter int MB_NUMBER_BITS = 12,
  parameter int PIPE_LAT       = PIPE_LAT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MB_NUMBER_BITS:0] num_mbs,
  input  logic                    stall,
  input  logic                    abort,
  output logic                    enable,
  output logic [MB_NUMBER_BITS:0] mbnumber,
  output logic                    mb_done,
  output logic                    busy,
  output logic                    done
);

  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(PIPE_LAT - 1);

  seq_state_e              state_q, state_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [MB_NUMBER_BITS:0] mb_q, mb_d;
  logic [MB_NUMBER_BITS:0] num_q, num_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      mb_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      mb_q    <= mb_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    mb_d    = mb_q;
    num_d   = num_q;
    enable  = 1'b0;
    mb_done = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        lat_d = '0;
        mb_d  = '0;
        if (start) begin
          num_d   = num_mbs;
          state_d = (num_mbs != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        enable = !stall;
        if (!stall) begin
          if (lat_q == LAT_LAST) begin
            mb_done = 1'b1;
            lat_d   = '0;
            if (mb_q == num_q - 1'b1) state_d = ST_DONE;
            else                      mb_d    = mb_q + 1'b1;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        // abort wins over completion, but the final mb_done above still shows
        if (abort) begin
          state_d = ST_IDLE;
          lat_d   = '0;
          mb_d    = '0;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = !abort;
        state_d = ST_IDLE;
        mb_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
        mb_d    = '0;
      end
    endcase
  end

  assign mbnumber = mb_q;

endmodule

// File: tb/tb_intrapred_sequencer.sv
// tb/tb_intrapred_sequencer.sv - scoreboard bench for intrapred_sequencer
module tb_intrapred_sequencer;

  localparam int MBB = 12;
  localparam int L   = 5;

  logic           clk;
  logic           reset;
  logic           start;
  logic [MBB:0]   num_mbs;
  logic           stall;
  logic           abort;
  logic           enable;
  logic [MBB:0]   mbnumber;
  logic           mb_done;
  logic           busy;
  logic           done;

  intrapred_sequencer #(.MB_NUMBER_BITS(MBB), .PIPE_LAT(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_mbs  (num_mbs),
    .stall    (stall),
    .abort    (abort),
    .enable   (enable),
    .mbnumber (mbnumber),
    .mb_done  (mb_done),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int cyc;
    bit kind;   // 0 = mb_done, 1 = done
    int mb;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  en_cnt = 0;
  int  bz_cnt = 0;
  int  s_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic void push_mb(int s, int i, int ext);
    ev_t e;
    e.cyc = s + (i + 1) * L - 1 + ext;
    e.kind = 1'b0;
    e.mb = i;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(int s, int n, int ext);
    ev_t e;
    e.cyc = s + n * L + ext;
    e.kind = 1'b1;
    e.mb = (n == 0) ? 0 : n - 1;
    exp_q.push_back(e);
  endfunction

  // monitor: every mb_done / done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (enable) en_cnt++;
      if (busy) bz_cnt++;
      if (mb_done || done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event_cycle", cyc, -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_kind", done, mon_e.kind);
          chk("event_cycle", cyc, mon_e.cyc);
          chk("event_mbnumber", mbnumber, mon_e.mb);
        end
      end
    end
  end

  // caller is at a negedge; returns at acceptance edge + 1 (cycle 1 of the frame)
  task automatic start_now(input int n);
    en_cnt = 0;
    bz_cnt = 0;
    start = 1'b1;
    num_mbs = n[MBB:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start_now(n);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("idle_reached", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_mbs = '0;
    stall = 1'b0;
    abort = 1'b0;
    #3;
    chk("rst_enable", enable, 0);
    chk("rst_mbnumber", mbnumber, 0);
    chk("rst_mb_done", mb_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // start on the very first edge after reset release, one-MB frame
    @(negedge clk);
    reset = 1'b1;
    start_now(1);
    push_mb(s_cyc, 0, 0);
    push_done(s_cyc, 1, 0);
    wait_idle(40);
    chk("first_start_en_cycles", en_cnt, 5);

    // three MBs, no stall: 15 enable cycles, done at cycle 16
    do_start(3);
    for (int i = 0; i < 3; i++) push_mb(s_cyc, i, 0);
    push_done(s_cyc, 3, 0);
    cycles(6);
    chk("n3_mbnumber_cycle7", mbnumber, 1);
    wait_idle(60);
    chk("n3_en_cycles", en_cnt, 15);
    chk("n3_busy_cycles", bz_cnt, 16);
    chk("n3_idle_mbnumber", mbnumber, 0);

    // two MBs, stall for 3 cycles at MB0 lat_cnt=2
    do_start(2);
    push_mb(s_cyc, 0, 3);
    push_mb(s_cyc, 1, 3);
    push_done(s_cyc, 2, 3);
    cycles(2);
    stall = 1'b1;
    cycles(1);
    chk("stall_enable", enable, 0);
    chk("stall_mbnumber", mbnumber, 0);
    chk("stall_busy", busy, 1);
    cycles(2);
    stall = 1'b0;
    wait_idle(60);
    chk("stall_en_cycles", en_cnt, 10);

    // empty frame: done next cycle, no enable, busy one cycle
    do_start(0);
    push_done(s_cyc, 0, 0);
    wait_idle(20);
    chk("n0_en_cycles", en_cnt, 0);
    chk("n0_busy_cycles", bz_cnt, 1);

    // abort at MB1 lat_cnt=3
    do_start(4);
    push_mb(s_cyc, 0, 0);
    cycles(8);
    chk("abort_pre_mbnumber", mbnumber, 1);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mbnumber", mbnumber, 0);
    wait_idle(20);
    chk("abort_en_cycles", en_cnt, 9);
    do_start(2);
    for (int i = 0; i < 2; i++) push_mb(s_cyc, i, 0);
    push_done(s_cyc, 2, 0);
    wait_idle(40);

    // abort coinciding with the final mb_done: mb_done yes, done no
    do_start(1);
    push_mb(s_cyc, 0, 0);
    cycles(4);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    chk("abort_last_busy", busy, 0);
    wait_idle(20);

    // start and num_mbs changes during RUN are ignored
    do_start(2);
    for (int i = 0; i < 2; i++) push_mb(s_cyc, i, 0);
    push_done(s_cyc, 2, 0);
    cycles(2);
    start = 1'b1;
    num_mbs = 13'd5;
    cycles(1);
    start = 1'b0;
    num_mbs = 13'd7;
    wait_idle(60);
    chk("ignored_start_en_cycles", en_cnt, 10);
    chk("ignored_start_busy_cycles", bz_cnt, 11);

    // asynchronous reset mid-frame at MB2
    do_start(4);
    for (int i = 0; i < 4; i++) push_mb(s_cyc, i, 0);
    push_done(s_cyc, 4, 0);
    cycles(11);
    chk("midrst_pre_mbnumber", mbnumber, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_enable", enable, 0);
    chk("midrst_mbnumber", mbnumber, 0);
    chk("midrst_mb_done", mb_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    start_now(1);
    push_mb(s_cyc, 0, 0);
    push_done(s_cyc, 1, 0);
    wait_idle(40);

    // largest frame: last mbnumber 8190, one done
    do_start(8191);
    for (int i = 0; i < 8191; i++) push_mb(s_cyc, i, 0);
    push_done(s_cyc, 8191, 0);
    wait_idle(45000);
    chk("max_en_cycles", en_cnt, 8191 * L);
    chk("max_idle_mbnumber", mbnumber, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
